debounce_pulse_array: RTL
=========================

DEBOUNCE_PULSE_ARRAY -- requirements
Module: debounce_pulse_array

Interface
REQ-001 SHALL have parameter N, default 4: number of independent push-button channels (1..32).
REQ-002 SHALL have parameter DB_CNT, default 16: consecutive sample ticks of a stable differing level needed to flip a channel (2..65535).
REQ-003 SHALL have parameter RPT_DELAY, default 64: sample ticks a channel is held before the first auto-repeat pulse (1..65535).
REQ-004 SHALL have parameter RPT_PERIOD, default 16: sample ticks between later auto-repeat pulses (1..65535).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sample_en, input, 1 bit: debounce/repeat tick qualifier; counters advance only when it is 1.
REQ-008 SHALL have port rpt_en, input, N bits: per-channel auto-repeat enable.
REQ-009 SHALL have port pb_in, input, N bits: raw asynchronous button levels, active-high.
REQ-010 SHALL have port db_level, output, N bits: debounced level per channel.
REQ-011 SHALL have port press, output, N bits: one-clk pulse on debounced rise and on each auto-repeat.
REQ-012 SHALL have port release, output, N bits: one-clk pulse on debounced fall.
REQ-013 SHALL have port any_press, output, 1 bit: OR-reduction of press, registered in the same cycle as press.

Function
REQ-014 SHALL pass each pb_in bit through a 2-flop synchronizer before any other logic; its output is called s[i].
REQ-015 SHALL keep a per-channel stability counter of width clog2(DB_CNT+1), cleared whenever s[i] equals db_level[i].
REQ-016 SHALL increment that counter on a sample_en cycle where s[i] differs from db_level[i], and hold it when sample_en is 0.
REQ-017 SHALL, on the edge where the counter would reach DB_CNT, invert db_level[i] and clear the counter.
REQ-018 SHALL assert press[i] for exactly the first clk cycle in which db_level[i] is 1 after being 0, and release[i] for exactly the first cycle in which it is 0 after being 1.
REQ-019 SHALL hold press and release low on all other cycles, independent of sample_en width or duty.
REQ-020 SHALL run a per-channel repeat FSM with states IDLE, WAIT_DELAY and REPEAT.
REQ-021 SHALL take the repeat FSM IDLE->WAIT_DELAY on a debounced rise when rpt_en[i]=1, loading a repeat counter with RPT_DELAY.
REQ-022 SHALL decrement the repeat counter on sample_en, and when it reaches 0 pulse press[i] for one cycle, enter REPEAT and reload it with RPT_PERIOD; in REPEAT the same reload-and-pulse SHALL happen at each expiry.
REQ-023 SHALL return the repeat FSM to IDLE in the same cycle db_level[i] falls or rpt_en[i] is 0, and SHALL then issue no further repeat pulse.
REQ-024 SHALL size the repeat counter to clog2(max(RPT_DELAY,RPT_PERIOD)+1) bits; it must not wrap.
REQ-025 SHALL keep channels fully independent, so simultaneous events on several channels each produce their own pulse in the same cycle.
REQ-026 SHALL treat a glitch shorter than DB_CNT sample ticks as no event: the counter clears and no pulse or level change occurs.
REQ-027 SHALL give end-to-end latency, from a pb_in change to the db_level change, of 2 clk plus DB_CNT sample_en cycles.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear the synchronizers, counters, db_level, press, release and any_press to 0 and set every FSM to IDLE.
REQ-029 SHALL resume on the first clk edge after rst_n deasserts; a button held through reset SHALL produce one press after the REQ-027 latency.
REQ-030 SHALL, on reset mid-debounce or mid-repeat, abandon that activity with no pulse emitted.

Verification (N=4, DB_CNT=4, RPT_DELAY=8, RPT_PERIOD=3, sample_en=1 unless stated)
REQ-031 SHALL check a clean press: pb_in[0] 0->1 held 20 clk -> db_level[0] rises 6 clk after the change; press[0] and any_press are high for 1 clk there; no other pulse.
REQ-032 SHALL check glitch rejection: pb_in[1] high for 3 clk, then low -> db_level, press and release all stay 0.
REQ-033 SHALL check auto-repeat: rpt_en[2]=1 and pb_in[2] held 30 clk -> press[2] at the rise, then at +8, +11, +14 ...; it stops on release, with release[2] pulsing once.
REQ-034 SHALL check simultaneous press: pb_in=4'b1011 in one cycle -> press=4'b1011 for 1 clk, then 0.
REQ-035 SHALL check the sample_en divider: sample_en every 4th clk and pb_in[3] held -> db_level[3] rises after 2 clk plus 4 sample_en ticks; press[3] is exactly 1 clk wide.
REQ-036 SHALL check reset mid-operation: rst_n=0 during WAIT_DELAY -> all outputs 0 at once; after release of reset with the button still held -> a single press after 6 clk.

Source files
------------

// File: rtl/debounce_pulse_array.sv
// Bank of N push-button debouncers with per-channel press/release pulses and
// optional auto-repeat. release_pulse carries the one-cycle debounced-fall pulse.
module debounce_pulse_array #(
    parameter int N          = 4,
    parameter int DB_CNT     = 16,
    parameter int RPT_DELAY  = 64,
    parameter int RPT_PERIOD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic [N-1:0] rpt_en,
    input  logic [N-1:0] pb_in,
    output logic [N-1:0] db_level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic         any_press
);

    localparam int CNT_W   = $clog2(DB_CNT + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CNT - 1);
    localparam logic [RPT_W-1:0] DELAY_VAL  = RPT_W'(RPT_DELAY);
    localparam logic [RPT_W-1:0] PERIOD_VAL = RPT_W'(RPT_PERIOD);

    typedef enum logic [1:0] {IDLE, WAIT_DELAY, REPEAT} rpt_state_e;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] press_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            any_press <= 1'b0;
        end else begin
            sync1     <= pb_in;
            sync2     <= sync1;
            any_press <= |press_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic             s;
        logic             lvl;
        logic             pr;
        logic             rl;
        logic [CNT_W-1:0] cnt;
        logic [RPT_W-1:0] rcnt;
        rpt_state_e       state;
        logic             flip;
        logic             rise;
        logic             fall;
        logic             abort;
        logic             rpt_pulse;

        assign s    = sync2[i];
        assign flip = sample_en && (s != lvl) && (cnt == DB_LAST);
        assign rise = flip && !lvl;
        assign fall = flip && lvl;

        // A falling level or a dropped enable kills the repeat before any pulse on that edge
        assign abort     = fall || !rpt_en[i];
        assign rpt_pulse = (state != IDLE) && !abort && sample_en && (rcnt == RPT_W'(1));

        assign press_d[i]       = rise || rpt_pulse;
        assign db_level[i]      = lvl;
        assign press[i]         = pr;
        assign release_pulse[i] = rl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl   <= 1'b0;
                pr    <= 1'b0;
                rl    <= 1'b0;
                cnt   <= '0;
                rcnt  <= '0;
                state <= IDLE;
            end else begin
                pr <= press_d[i];
                rl <= fall;

                if (s == lvl) begin
                    cnt <= '0;
                end else if (flip) begin
                    cnt <= '0;
                    lvl <= ~lvl;
                end else if (sample_en) begin
                    cnt <= cnt + CNT_W'(1);
                end

                case (state)
                    IDLE: begin
                        if (rise && rpt_en[i]) begin
                            state <= WAIT_DELAY;
                            rcnt  <= DELAY_VAL;
                        end
                    end
                    WAIT_DELAY, REPEAT: begin
                        if (abort) begin
                            state <= IDLE;
                            rcnt  <= '0;
                        end else if (sample_en) begin
                            if (rcnt == RPT_W'(1)) begin
                                state <= REPEAT;
                                rcnt  <= PERIOD_VAL;
                            end else begin
                                rcnt <= rcnt - RPT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
